// File: rtl/axi_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : axi_arb_pkg
//  Purpose  : Shared types and constants for the AXI read-channel arbiter.
//             These are the arbiter FSM states, the requester encoding,
//             the AXI OKAY response code and the default AXI IDs.
//  Revision : 1.0  initial release
// ============================================================================
package axi_arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } arb_state_t;

    typedef enum logic [0:0] {
        REQ_INST = 1'b0,
        REQ_DATA = 1'b1
    } requester_t;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [3:0] DEFAULT_INST_ID = 4'd0;
    localparam logic [3:0] DEFAULT_DATA_ID = 4'd1;

endpackage
`default_nettype wire

// File: rtl/axi_outstanding_counter.sv
`default_nettype none
// ============================================================================
//  Module   : axi_outstanding_counter
//  Purpose  : Tracks in-flight reads for one requester. The count saturates at
//             0 and at MAX_OUTSTANDING. When inc and dec arrive together, the
//             count is left unchanged.
//  Revision : 1.0  initial release
// ============================================================================
module axi_outstanding_counter #(
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic inc,
    input  logic dec,
    output logic full
);

    localparam int                CNT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAX_OUTSTANDING);

    logic [CNT_W-1:0] count;

    // Saturating up/down count of reads issued but not yet completed
    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else begin
            case ({inc, dec})
                2'b10:   if (count != CNT_MAX) count <= count + 1'b1;
                2'b01:   if (count != '0)      count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign full = (count == CNT_MAX);

endmodule
`default_nettype wire

// File: rtl/axi_read_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : axi_read_arbiter
//  Purpose  : Shares one AXI AR/R channel pair between the instruction-fetch
//             and data-load requesters. It issues registered ARs, applies an
//             outstanding limit per requester, blocks read-after-write hazards
//             and routes R beats by ID.
//  Options  : AXI_ARB_ROUND_ROBIN_EN replaces data priority and the starvation
//             guard with round-robin arbitration.
//  Revision : 1.0  initial release
// ============================================================================
module axi_read_arbiter
    import axi_arb_pkg::*;
#(
    parameter int         ADDR_W          = 32,
    parameter int         MAX_OUTSTANDING = 2,
    parameter int         STARVE_LIMIT    = 4,
    parameter logic [3:0] INST_ID         = DEFAULT_INST_ID,
    parameter logic [3:0] DATA_ID         = DEFAULT_DATA_ID
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              inst_req_valid,
    output logic              inst_req_ready,
    input  logic [ADDR_W-1:0] inst_req_addr,
    input  logic [2:0]        inst_req_size,
    output logic              inst_rsp_valid,
    input  logic              inst_rsp_ready,
    output logic [ADDR_W-1:0] inst_rsp_data,
    input  logic              data_req_valid,
    output logic              data_req_ready,
    input  logic [ADDR_W-1:0] data_req_addr,
    input  logic [2:0]        data_req_size,
    output logic              data_rsp_valid,
    input  logic              data_rsp_ready,
    output logic [ADDR_W-1:0] data_rsp_data,
    input  logic              wr_pending,
    input  logic [ADDR_W-1:0] wr_pending_addr,
    output logic [3:0]        ar_id,
    output logic [ADDR_W-1:0] ar_addr,
    output logic [2:0]        ar_size,
    output logic              ar_valid,
    input  logic              ar_ready,
    input  logic [3:0]        r_id,
    input  logic [ADDR_W-1:0] r_data,
    input  logic [1:0]        r_resp,
    input  logic              r_last,
    input  logic              r_valid,
    output logic              r_ready,
    output logic              rsp_err
);

    arb_state_t state, next_state;
    logic grant_inst, grant_data, pick_inst;
    logic inst_full, data_full;
    logic inst_hazard, data_hazard, inst_eligible, data_eligible;
    logic id_is_inst, id_is_data, id_unknown, r_fire;

    // A read is held only while the pending write targets the same word.
    assign inst_hazard   = wr_pending && (wr_pending_addr[ADDR_W-1:2] == inst_req_addr[ADDR_W-1:2]);
    assign data_hazard   = wr_pending && (wr_pending_addr[ADDR_W-1:2] == data_req_addr[ADDR_W-1:2]);
    assign inst_eligible = inst_req_valid && !inst_full && !inst_hazard;
    assign data_eligible = data_req_valid && !data_full && !data_hazard;

`ifdef AXI_ARB_ROUND_ROBIN_EN
    requester_t last_grant;

    // On contention, the requester not granted last time wins.
    assign pick_inst = inst_eligible && (!data_eligible || (last_grant == REQ_DATA));

    // Remember who won the most recent arbitration
    always_ff @(posedge clock) begin
        if (reset)           last_grant <= REQ_INST;
        else if (grant_inst) last_grant <= REQ_INST;
        else if (grant_data) last_grant <= REQ_DATA;
    end
`else
    localparam int                   STARVE_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [STARVE_W-1:0]  STARVE_MAX = STARVE_W'(STARVE_LIMIT);
    logic [STARVE_W-1:0] starve_count;

    // Data wins contention unless instruction fetch has lost too many times in a row.
    assign pick_inst = inst_eligible && (!data_eligible || (starve_count >= STARVE_MAX));

    // Count arbitrations lost by an eligible instruction request
    always_ff @(posedge clock) begin
        if (reset)
            starve_count <= '0;
        else if (grant_inst)
            starve_count <= '0;
        else if (grant_data && inst_eligible && (starve_count != STARVE_MAX))
            starve_count <= starve_count + 1'b1;
    end
`endif

    // AR state register
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Grant selection in IDLE; ISSUE waits for the AR handshake.
    always_comb begin
        next_state = state;
        grant_inst = 1'b0;
        grant_data = 1'b0;
        case (state)
            IDLE: begin
                if (pick_inst) begin
                    grant_inst = 1'b1;
                    next_state = ISSUE;
                end else if (data_eligible) begin
                    grant_data = 1'b1;
                    next_state = ISSUE;
                end
            end
            ISSUE:   if (ar_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign inst_req_ready = grant_inst;
    assign data_req_ready = grant_data;
    assign ar_valid       = (state == ISSUE);

    // Capture the granted request so AR stays stable while it is stalled.
    always_ff @(posedge clock) begin
        if (reset) begin
            ar_id   <= '0;
            ar_addr <= '0;
            ar_size <= '0;
        end else if (grant_inst) begin
            ar_id   <= INST_ID;
            ar_addr <= inst_req_addr;
            ar_size <= inst_req_size;
        end else if (grant_data) begin
            ar_id   <= DATA_ID;
            ar_addr <= data_req_addr;
            ar_size <= data_req_size;
        end
    end

    // R routing: the instruction ID takes precedence if both IDs are equal. Unknown IDs are sunk.
    assign id_is_inst     = (r_id == INST_ID);
    assign id_is_data     = (r_id == DATA_ID) && !id_is_inst;
    assign id_unknown     = !id_is_inst && !id_is_data;
    assign inst_rsp_valid = r_valid && id_is_inst;
    assign data_rsp_valid = r_valid && id_is_data;
    assign inst_rsp_data  = r_data;
    assign data_rsp_data  = r_data;
    assign r_ready        = id_is_inst ? inst_rsp_ready :
                            id_is_data ? data_rsp_ready : 1'b1;
    assign r_fire         = r_valid && r_ready;

    // Sticky error for accepted beats that are misrouted or carry a bad response
    always_ff @(posedge clock) begin
        if (reset)
            rsp_err <= 1'b0;
        else if (r_fire && (id_unknown || (r_resp != AXI_RESP_OKAY)))
            rsp_err <= 1'b1;
    end

    axi_outstanding_counter #(.MAX_OUTSTANDING(MAX_OUTSTANDING)) u_inst_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (grant_inst),
        .dec   (r_fire && r_last && id_is_inst),
        .full  (inst_full)
    );

    axi_outstanding_counter #(.MAX_OUTSTANDING(MAX_OUTSTANDING)) u_data_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (grant_data),
        .dec   (r_fire && r_last && id_is_data),
        .full  (data_full)
    );

endmodule
`default_nettype wire
